// File: rtl/regfile_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_seq_pkg
//  Purpose  : Shared encodings and default widths for the register-file
//             operation sequencer (ALU op codes, FSM state codes).
//  Revision : 1.0  initial release
// ============================================================================
package regfile_seq_pkg;

  // Default datapath / address widths (8 registers of 8 bits)
  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 3;

  // ALU operation encoding, as carried on cmd_op
  typedef logic [1:0] op_t;
  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_AND = 2'b10;
  localparam op_t OP_XOR = 2'b11;

  // Sequencer state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/regfile_op_sequencer_alu.sv
`default_nettype none
// ============================================================================
//  Module   : rfseq_alu
//  Purpose  : Combinational ALU for the sequencer. Produces a result one bit
//             wider than the operands so ADD carry and SUB borrow fall out of
//             the top bit directly.
//  Revision : 1.0  initial release
// ============================================================================
module rfseq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_t           op,
  output logic [DW-1:0] res,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] wide;

  // Zero-extended arithmetic: the MSB is carry for ADD and borrow (a < b) for SUB
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
  end

  assign res   = wide[DW-1:0];
  assign carry = wide[DW];
  assign zero  = (wide[DW-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_op_sequencer
//  Purpose  : Initiator-side controller for a 2R/1W register file. Accepts an
//             ALU command, reads both sources, computes, writes the result
//             back and returns it with zero/carry flags.
//             IDLE -> READ -> EXEC -> WRITE -> RESP -> IDLE (5 cycles min).
//  Revision : 1.0  initial release
// ============================================================================
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int AW      = DEFAULT_AW,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  // register file ports
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_carry
);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          accept;
  logic          wr_allowed;
  op_t           op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          alu_zero;

  // cmd_ready is registered, so it already implies IDLE; the state term keeps
  // the intent explicit.
  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

  // Optional hard-wired-zero R0: suppress the write strobe, keep the response
  generate
    if (R0_ZERO) begin : g_r0_zero
      assign wr_allowed = (rd_q != '0);
    end else begin : g_r0_normal
      assign wr_allowed = 1'b1;
    end
  endgenerate

  // Next-state decode for the fixed command sequence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Handshake and write strobe are registered from the next state so that
  // they are glitch-free and low throughout reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rf_we     <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
      rf_we     <= (state_nxt == S_WRITE) && wr_allowed;
    end
  end

  // Latch the command and present the read addresses for the READ cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_ADD;
      rd_q      <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
    end else if (accept) begin
      op_q      <= cmd_op;
      rd_q      <= cmd_rd;
      rf_raddr1 <= cmd_rs1;
      rf_raddr2 <= cmd_rs2;
    end
  end

  // Capture operands at the end of READ (register file reads are combinational)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_READ) begin
      a_q <= rf_rdata1;
      b_q <= rf_rdata2;
    end
  end

  rfseq_alu #(
    .DW (DW)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // Register the ALU result and write address at the end of EXEC; these hold
  // through WRITE and RESP until the next command's EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q     <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rf_waddr  <= '0;
    end else if (state == S_EXEC) begin
      res_q     <= alu_res;
      rsp_zero  <= alu_zero;
      rsp_carry <= alu_carry;
      rf_waddr  <= rd_q;
    end
  end

  assign rf_wdata = res_q;
  assign rsp_data = res_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_op_sequencer
//  Purpose  : Self-checking bench. Two sequencers (R0 suppressed / not) run
//             the same command stream, each against its own register file
//             array, and are checked against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs1;
  logic [2:0] cmd_rs2;
  logic       rsp_ready;

  // instance with R0 suppression (_z) and without (_n)
  logic       cmd_ready_z, rf_we_z, rsp_valid_z, rsp_zero_z, rsp_carry_z;
  logic [2:0] raddr1_z, raddr2_z, waddr_z;
  logic [7:0] rdata1_z, rdata2_z, wdata_z, rsp_data_z;
  logic       cmd_ready_n, rf_we_n, rsp_valid_n, rsp_zero_n, rsp_carry_n;
  logic [2:0] raddr1_n, raddr2_n, waddr_n;
  logic [7:0] rdata1_n, rdata2_n, wdata_n, rsp_data_n;

  // external register files and their reference images
  logic [7:0] rf_z [8];
  logic [7:0] rf_n [8];
  logic [7:0] init_vals [8];
  logic [7:0] ref_z [8];
  logic [7:0] ref_n [8];
  logic       load;

  int n_tests;
  int n_fail;

  regfile_op_sequencer #(.DW(8), .AW(3), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rf_raddr1(raddr1_z), .rf_raddr2(raddr2_z),
    .rf_rdata1(rdata1_z), .rf_rdata2(rdata2_z),
    .rf_we(rf_we_z), .rf_waddr(waddr_z), .rf_wdata(wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready), .rsp_data(rsp_data_z),
    .rsp_zero(rsp_zero_z), .rsp_carry(rsp_carry_z)
  );

  regfile_op_sequencer #(.DW(8), .AW(3), .R0_ZERO(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rf_raddr1(raddr1_n), .rf_raddr2(raddr2_n),
    .rf_rdata1(rdata1_n), .rf_rdata2(rdata2_n),
    .rf_we(rf_we_n), .rf_waddr(waddr_n), .rf_wdata(wdata_n),
    .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready), .rsp_data(rsp_data_n),
    .rsp_zero(rsp_zero_n), .rsp_carry(rsp_carry_n)
  );

  assign rdata1_z = rf_z[raddr1_z];
  assign rdata2_z = rf_z[raddr2_z];
  assign rdata1_n = rf_n[raddr1_n];
  assign rdata2_n = rf_n[raddr2_n];

  // register file behaviour: combinational read, write at the clock edge
  always @(posedge clk) begin
    if (load) begin
      rf_z <= init_vals;
      rf_n <= init_vals;
    end else begin
      if (rf_we_z) rf_z[waddr_z] <= wdata_z;
      if (rf_we_n) rf_n[waddr_n] <= wdata_n;
    end
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU: plain integer arithmetic
  task automatic model_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic carry);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'd0: begin r = ai + bi; carry = (r > 255); end
      2'd1: begin r = ai - bi; carry = (ai < bi); if (r < 0) r = r + 256; end
      2'd2: begin r = ai & bi; carry = 1'b0; end
      default: begin r = ai ^ bi; carry = 1'b0; end
    endcase
    res = 8'(r & 255);
  endtask

  // Issue one command from IDLE (called #1 after a rising edge) and follow it
  // cycle by cycle. hold = extra RESP cycles with rsp_ready low; kill = reset
  // asserted in the middle of WRITE.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input int hold, input bit kill);
    logic [7:0] ez, en;
    logic       cz, cn;
    bit         wz;
    model_op(op, ref_z[rs1], ref_z[rs2], ez, cz);
    model_op(op, ref_n[rs1], ref_n[rs2], en, cn);
    wz = (rd != 3'd0);

    check_eq("idle_ready_z", cmd_ready_z, 1);
    check_eq("idle_ready_n", cmd_ready_n, 1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    @(posedge clk); #1;
    // READ: keep offering junk commands and a random rsp_ready; both ignored
    cmd_op = 2'($urandom); cmd_rd = 3'($urandom);
    cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom);
    rsp_ready = 1'($urandom_range(0, 1));
    check_eq("read_raddr1_z", raddr1_z, rs1);
    check_eq("read_raddr2_z", raddr2_z, rs2);
    check_eq("read_raddr1_n", raddr1_n, rs1);
    check_eq("read_raddr2_n", raddr2_n, rs2);
    check_eq("busy_ready_z", cmd_ready_z, 0);
    check_eq("read_we_z", rf_we_z, 0);
    check_eq("read_valid_z", rsp_valid_z, 0);
    @(posedge clk); #1;
    // EXEC
    check_eq("exec_we_z", rf_we_z, 0);
    check_eq("exec_we_n", rf_we_n, 0);
    check_eq("exec_valid_z", rsp_valid_z, 0);
    @(posedge clk); #1;
    // WRITE
    check_eq("write_we_z", rf_we_z, wz);
    check_eq("write_we_n", rf_we_n, 1);
    if (wz) begin
      check_eq("write_waddr_z", waddr_z, rd);
      check_eq("write_wdata_z", wdata_z, ez);
    end
    check_eq("write_waddr_n", waddr_n, rd);
    check_eq("write_wdata_n", wdata_n, en);
    check_eq("write_valid_z", rsp_valid_z, 0);

    if (kill) begin
      #2 rst = 1'b0;
      #1;
      check_eq("kill_we_z", rf_we_z, 0);
      check_eq("kill_we_n", rf_we_n, 0);
      check_eq("kill_ready_z", cmd_ready_z, 0);
      @(posedge clk); #1;
      check_eq("kill_rf_z", rf_z[rd], ref_z[rd]);
      check_eq("kill_rf_n", rf_n[rd], ref_n[rd]);
      check_eq("kill_valid_n", rsp_valid_n, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check_eq("kill_rel_ready_z", cmd_ready_z, 1);
      check_eq("kill_rel_ready_n", cmd_ready_n, 1);
      return;
    end

    if (wz) ref_z[rd] = ez;
    ref_n[rd] = en;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    // RESP
    check_eq("resp_valid_z", rsp_valid_z, 1);
    check_eq("resp_data_z", rsp_data_z, ez);
    check_eq("resp_zero_z", rsp_zero_z, (ez == 8'd0));
    check_eq("resp_carry_z", rsp_carry_z, cz);
    check_eq("resp_valid_n", rsp_valid_n, 1);
    check_eq("resp_data_n", rsp_data_n, en);
    check_eq("resp_zero_n", rsp_zero_n, (en == 8'd0));
    check_eq("resp_carry_n", rsp_carry_n, cn);
    check_eq("resp_we_z", rf_we_z, 0);
    check_eq("resp_we_n", rf_we_n, 0);
    check_eq("wb_rf_z", rf_z[rd], ref_z[rd]);
    check_eq("wb_rf_n", rf_n[rd], ref_n[rd]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid_z", rsp_valid_z, 1);
      check_eq("hold_data_z", rsp_data_z, ez);
      check_eq("hold_carry_z", rsp_carry_z, cz);
      check_eq("hold_ready_z", cmd_ready_z, 0);
      check_eq("hold_data_n", rsp_data_n, en);
    end
    rsp_ready = 1'b1;
    if (hold != 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    // back in IDLE
    check_eq("done_valid_z", rsp_valid_z, 0);
    check_eq("done_valid_n", rsp_valid_n, 0);
    check_eq("done_ready_z", cmd_ready_z, 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  // bounded run time: never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    rsp_ready = 1'b0;
    init_vals[0] = 8'h00; init_vals[1] = 8'hAA; init_vals[2] = 8'h55;
    init_vals[3] = 8'h00; init_vals[4] = 8'h00; init_vals[5] = 8'h3C;
    init_vals[6] = 8'hFF; init_vals[7] = 8'h01;
    ref_z = init_vals;
    ref_n = init_vals;
    load = 1'b1;

    // reset held with cmd_valid high: everything stays quiet
    repeat (3) @(posedge clk);
    #1;
    load = 1'b0;
    check_eq("rst_ready_z", cmd_ready_z, 0);
    check_eq("rst_we_z", rf_we_z, 0);
    check_eq("rst_valid_z", rsp_valid_z, 0);
    check_eq("rst_ready_n", cmd_ready_n, 0);
    check_eq("rst_data_z", rsp_data_z, 0);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_ready_z", cmd_ready_z, 1);

    // directed scenarios
    do_cmd(2'd0, 3'd3, 3'd1, 3'd2, 0, 1'b0);  // ADD 0xAA+0x55 = 0xFF
    do_cmd(2'd1, 3'd4, 3'd2, 3'd1, 0, 1'b0);  // SUB 0x55-0xAA = 0xAB, borrow
    do_cmd(2'd3, 3'd5, 3'd1, 3'd1, 0, 1'b0);  // XOR same reg = 0
    do_cmd(2'd2, 3'd0, 3'd1, 3'd2, 5, 1'b0);  // AND to R0, with backpressure
    do_cmd(2'd0, 3'd6, 3'd6, 3'd7, 0, 1'b0);  // ADD 0xFF+0x01 wraps, carry
    do_cmd(2'd0, 3'd1, 3'd6, 3'd7, 0, 1'b0);  // dependent ADD sees R6=0

    // randomized commands
    for (int k = 0; k < 40; k++) begin
      do_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    // reset during WRITE abandons the command without writing
    do_cmd(2'd0, 3'd2, 3'd1, 3'd7, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Initiator-side controller for the 8x8 two-read/one-write register file.
- Accepts ALU-style commands over a valid/ready handshake and reads two source registers through the file's read ports.
- Computes an 8-bit result, writes it back through the file's write port, then returns the result and flags on a response handshake.
- Sits between the command source and the register file. The register file itself is external.

Parameters:
- DW, 8, data width; must match the register file word width.
- AW, 3, register address width (8 registers).
- R0_ZERO, 1, when 1, writes to address 0 are suppressed (rf_we stays low); the response is still produced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_op  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source A register.
- cmd_rs2  in  AW  source B register.
- rf_raddr1  out  AW  register file read address 1.
- rf_raddr2  out  AW  register file read address 2.
- rf_rdata1  in  DW  register file read data 1 (combinational read of rf_raddr1).
- rf_rdata2  in  DW  register file read data 2.
- rf_we  out  1  register file write enable.
- rf_waddr  out  AW  register file write address.
- rf_wdata  out  DW  register file write data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DW  result.
- rsp_zero  out  1  result == 0.
- rsp_carry  out  1  ADD: carry out; SUB: borrow (A < B unsigned); AND/XOR: 0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including cmd_ready and rf_we; internal latches cleared.
- After rst deasserts, cmd_ready=1 from the first clock edge.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- FSM IDLE -> READ -> EXEC -> WRITE -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge E0, latch op/rd/rs1/rs2 and go to READ.
- READ (cycle after E0):
  - rf_raddr1=rs1, rf_raddr2=rs2 (registered outputs, valid for the whole cycle).
  - At the end of the cycle, capture rf_rdata1 -> A and rf_rdata2 -> B.
  - rf_raddr1/2 hold their last value outside READ.
- EXEC: compute a (DW+1)-bit result.
  - ADD: {carry,res}=A+B.
  - SUB: {borrow,res}=A-B, with borrow = A<B.
  - AND/XOR: bitwise, carry=0.
  - Register res, zero, and carry.
- WRITE:
  - rf_we=1 for exactly one cycle, rf_waddr=rd, rf_wdata=res.
  - If R0_ZERO && rd==0, rf_we stays 0.
  - rf_waddr/rf_wdata hold their values after WRITE; rf_we returns to 0.
- RESP:
  - rsp_valid=1; rsp_data/zero/carry are stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid=0 the next cycle.
- Latency: 4 cycles from command acceptance to rsp_valid. Back-to-back throughput: 5 cycles per command minimum.
- Hazards: the write lands at the end of WRITE, before the next command's READ, so a dependent command always sees the updated value. No forwarding is needed.
- rs1==rs2 and rd equal to a source are legal and need no special handling.
- Commands are not accepted outside IDLE; cmd_valid is ignored there.
- rsp_ready outside RESP is ignored.
- Reset mid-operation: the command is abandoned and no write occurs after the reset edge. If reset lands during WRITE, rf_we drops asynchronously.

Decomposition:
- Package regfile_seq_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_AND/OP_XOR;
  - state encodings S_IDLE..S_RESP;
  - default widths DW=8, AW=3.
- Sub-module rfseq_alu: combinational; inputs a, b, op; outputs res, carry, zero. Instantiated once, with its result registered in EXEC.
- The FSM and datapath registers stay in the top.

Test Plan:
1. Reset, then idle:
   - Hold rst=0 with cmd_valid=1 -> cmd_ready=0, rf_we=0, rsp_valid=0.
   - Release rst -> cmd_ready=1 at the next edge.
2. ADD:
   - Register file model holds R1=0xAA, R2=0x55. Send ADD rd=3, rs1=1, rs2=2.
   - rf_raddr1=1 and rf_raddr2=2 in READ.
   - rf_we pulses once with waddr=3, wdata=0xFF, 3 cycles after acceptance.
   - rsp_data=0xFF, zero=0, carry=0, with rsp_valid at cycle 4.
3. SUB with borrow:
   - SUB rd=4, rs1=2, rs2=1 -> rsp_data=0xAB, carry=1, model R4=0xAB.
   - Then XOR rd=5, rs1=1, rs2=1 -> 0x00, zero=1, carry=0.
4. ADD wrap:
   - R6=0xFF, R7=0x01; ADD rd=6, rs1=6, rs2=7 -> wdata=0x00, zero=1, carry=1.
   - Dependent ADD rd=1, rs1=6, rs2=7 reads R6=0x00 -> result 0x01.
5. R0 suppression:
   - With R0_ZERO=1, AND rd=0, rs1=1, rs2=2 -> rf_we never asserts; rsp_data=0x00, zero=1.
   - With R0_ZERO=0, the same command writes addr 0.
6. Backpressure and reset:
   - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, and a second cmd_valid is ignored.
   - Assert rst during WRITE -> rf_we=0 immediately, and the model register is unchanged.
